// File: rtl/vm_pkg.sv
// ------------------------------------------------------------------
// vm_pkg : shared types, coin constants and change helpers
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package vm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_CREDIT = 4'b0010,
    ST_VEND   = 4'b0100,
    ST_CHANGE = 4'b1000
  } state_e;

  typedef logic [1:0] coin_t;

  localparam logic [7:0] C_COIN_5  = 8'd5;
  localparam logic [7:0] C_COIN_10 = 8'd10;
  localparam logic [7:0] C_COIN_25 = 8'd25;
  localparam logic [7:0] C_COIN_50 = 8'd50;

  function automatic logic [7:0] coin_value(input coin_t c);
    logic [7:0] v;
    case (c)
      2'd0:    v = C_COIN_5;
      2'd1:    v = C_COIN_10;
      2'd2:    v = C_COIN_25;
      default: v = C_COIN_50;
    endcase
    return v;
  endfunction

  // Largest coin not exceeding the balance; balance is always a multiple of 5.
  function automatic coin_t pick_change(input logic [7:0] bal);
    coin_t c;
    if (bal >= C_COIN_50)      c = 2'd3;
    else if (bal >= C_COIN_25) c = 2'd2;
    else if (bal >= C_COIN_10) c = 2'd1;
    else                       c = 2'd0;
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vm_txn_ctrl_if.sv
// ------------------------------------------------------------------
// vm_txn_ctrl_if : front-panel events in, balance/dispense/change out
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface vm_txn_ctrl_if;
  import vm_pkg::*;

  logic        coin_valid;
  coin_t       coin;
  logic        item_valid;
  logic [1:0]  item;
  logic        cancel;
  logic        change_ack;
  logic [7:0]  balance;
  logic [7:0]  state_out;
  logic        dispense;
  logic [1:0]  dispense_item;
  logic        change_valid;
  coin_t       change_coin;
  logic        coin_reject;
  logic        insufficient;

  modport master (
    output coin_valid, coin, item_valid, item, cancel, change_ack,
    input  balance, state_out, dispense, dispense_item, change_valid,
           change_coin, coin_reject, insufficient
  );

  modport slave (
    input  coin_valid, coin, item_valid, item, cancel, change_ack,
    output balance, state_out, dispense, dispense_item, change_valid,
           change_coin, coin_reject, insufficient
  );

endinterface

`default_nettype wire

// File: rtl/vm_timer.sv
// ------------------------------------------------------------------
// vm_timer : clearable saturating idle counter with expiry flag
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vm_timer #(
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

  logic [W-1:0] count_q, count_d;

  assign expired = (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (enable && !expired)
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

endmodule

`default_nettype wire

// File: rtl/vm_txn_ctrl.sv
// ------------------------------------------------------------------
// vm_txn_ctrl : vending transaction sequencer (credit, vend, change)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module vm_txn_ctrl
  import vm_pkg::*;
#(
  parameter int unsigned PRICE0  = 25,
  parameter int unsigned PRICE1  = 50,
  parameter int unsigned PRICE2  = 75,
  parameter int unsigned PRICE3  = 100,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic           clk,
  input  logic           rst,
  vm_txn_ctrl_if.slave   bus
);

  function automatic bit price_ok(input int unsigned p);
    return (p >= 5) && (p <= 255) && ((p % 5) == 0);
  endfunction

  generate
    if (!(price_ok(PRICE0) && price_ok(PRICE1) && price_ok(PRICE2) &&
          price_ok(PRICE3) && (TIMEOUT >= 1))) begin : g_bad_param
      $error("vm_txn_ctrl: prices must be multiples of 5 in 5..255 and TIMEOUT >= 1");
    end
  endgenerate

  function automatic logic [7:0] price_of(input logic [1:0] idx);
    logic [7:0] p;
    case (idx)
      2'd0:    p = PRICE0[7:0];
      2'd1:    p = PRICE1[7:0];
      2'd2:    p = PRICE2[7:0];
      default: p = PRICE3[7:0];
    endcase
    return p;
  endfunction

  state_e      state_q, state_d;
  logic [7:0]  balance_q, balance_d;
  logic [1:0]  item_q, item_d;
  logic        dispense_q, dispense_d;
  logic        coin_reject_q, coin_reject_d;
  logic        insufficient_q, insufficient_d;

  logic        timer_clear;
  logic        timer_en;
  logic        timer_expired;

  logic [7:0]  coin_val;
  logic [8:0]  coin_sum;
  logic [7:0]  item_price;
  logic [7:0]  vend_rem;
  coin_t       change_sel;
  logic [7:0]  change_rem;

  assign coin_val   = coin_value(bus.coin);
  assign coin_sum   = {1'b0, balance_q} + {1'b0, coin_val};
  assign item_price = price_of(bus.item);
  assign vend_rem   = balance_q - price_of(item_q);
  assign change_sel = pick_change(balance_q);
  assign change_rem = balance_q - coin_value(change_sel);
  assign timer_en   = (state_q == ST_CREDIT);

  vm_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    balance_d      = balance_q;
    item_d         = item_q;
    dispense_d     = 1'b0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    timer_clear    = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.coin_valid) begin
          balance_d = coin_val;
          state_d   = ST_CREDIT;
        end else if (bus.item_valid) begin
          insufficient_d = 1'b1;
        end
      end
      ST_CREDIT: begin
        timer_clear = 1'b0;
        // Refund has top priority; a rejected coin still consumes the cycle.
        if (bus.cancel || timer_expired) begin
          state_d = ST_CHANGE;
        end else if (bus.coin_valid) begin
          if (!coin_sum[8]) begin
            balance_d   = coin_sum[7:0];
            timer_clear = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
        end else if (bus.item_valid) begin
          if (balance_q >= item_price) begin
            item_d     = bus.item;
            dispense_d = 1'b1;
            state_d    = ST_VEND;
          end else begin
            insufficient_d = 1'b1;
          end
        end
      end
      ST_VEND: begin
        coin_reject_d = bus.coin_valid;
        balance_d     = vend_rem;
        state_d       = (vend_rem != 8'd0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        coin_reject_d = bus.coin_valid;
        if (bus.change_ack) begin
          balance_d = change_rem;
          if (change_rem == 8'd0)
            state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        balance_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      balance_q      <= 8'd0;
      item_q         <= 2'd0;
      dispense_q     <= 1'b0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      balance_q      <= balance_d;
      item_q         <= item_d;
      dispense_q     <= dispense_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
    end
  end

  // change_coin follows the registered balance, so it holds until an ack.
  assign bus.balance       = balance_q;
  assign bus.state_out     = {4'b0000, state_q};
  assign bus.dispense      = dispense_q;
  assign bus.dispense_item = item_q;
  assign bus.change_valid  = (state_q == ST_CHANGE);
  assign bus.change_coin   = change_sel;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.insufficient  = insufficient_q;

endmodule

`default_nettype wire

// File: tb/tb_vm_txn_ctrl.sv
// ------------------------------------------------------------------
// tb_vm_txn_ctrl : scoreboard bench with a transaction-level model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_vm_txn_ctrl;

  localparam int TO = 20;
  localparam int EV_DISP = 0;
  localparam int EV_REJ  = 1;
  localparam int EV_INS  = 2;
  localparam int EV_CHG  = 3;
  localparam int M_IDLE = 0, M_CREDIT = 1, M_VEND = 2, M_CHANGE = 3;

  typedef struct { int st; int bal; int cv; int cc; } stat_t;
  typedef struct { int kind; int data; int bal; } evt_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vm_txn_ctrl_if bus();

  vm_txn_ctrl #(
    .PRICE0 (25), .PRICE1 (50), .PRICE2 (75), .PRICE3 (100), .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int price [4]      = '{25, 50, 75, 100};
  int coin_cents [4] = '{5, 10, 25, 50};
  int denom_val [4]  = '{50, 25, 10, 5};
  int denom_code [4] = '{3, 2, 1, 0};

  stat_t stat_q [$];
  evt_t  evt_q [$];
  int    checks   = 0;
  int    failures = 0;
  bit    mon_en   = 1'b0;

  // Model: state, credit, edges since the last accepted coin, pending payout.
  int m_state, m_bal, m_idle, m_item;
  int m_chg [$];

  task automatic m_reset();
    m_state = M_IDLE; m_bal = 0; m_idle = 0; m_item = 0;
    m_chg.delete();
  endtask

  task automatic enter_change();
    int b;
    b = m_bal;
    m_chg.delete();
    for (int i = 0; i < 4; i++)
      while (b >= denom_val[i]) begin
        m_chg.push_back(denom_code[i]);
        b -= denom_val[i];
      end
    m_state = M_CHANGE;
  endtask

  task automatic push_evt(int kind, int data, int bal);
    evt_t e;
    e.kind = kind; e.data = data; e.bal = bal;
    evt_q.push_back(e);
  endtask

  task automatic step(bit r, bit cv, bit [1:0] c, bit iv, bit [1:0] it, bit can, bit ack);
    stat_t s;
    bit    a;
    a = r ? ack : 1'b0;
    s.st  = 1 << m_state;
    s.bal = m_bal;
    s.cv  = (m_state == M_CHANGE) ? 1 : 0;
    s.cc  = (m_state == M_CHANGE) ? m_chg[0] : 0;
    stat_q.push_back(s);
    rst = r;
    bus.coin_valid = cv; bus.coin = c; bus.item_valid = iv; bus.item = it;
    bus.cancel = can; bus.change_ack = a;
    mon_en = 1'b1;
    if (!r) begin
      m_reset();
      return;
    end
    case (m_state)
      M_IDLE: begin
        if (cv) begin
          m_bal = coin_cents[c]; m_idle = 0; m_state = M_CREDIT;
        end else if (iv) begin
          push_evt(EV_INS, 0, m_bal);
        end
      end
      M_CREDIT: begin
        if (can || m_idle == TO) begin
          enter_change();
        end else if (cv) begin
          if (m_bal + coin_cents[c] > 255) begin
            push_evt(EV_REJ, 0, m_bal);
            m_idle++;
          end else begin
            m_bal += coin_cents[c];
            m_idle = 0;
          end
        end else if (iv) begin
          if (m_bal >= price[it]) begin
            m_item = it; m_state = M_VEND;
            push_evt(EV_DISP, it, m_bal);
          end else begin
            push_evt(EV_INS, 0, m_bal);
            m_idle++;
          end
        end else begin
          m_idle++;
        end
      end
      M_VEND: begin
        m_bal -= price[m_item];
        if (cv) push_evt(EV_REJ, 0, m_bal);
        if (m_bal > 0) enter_change();
        else m_state = M_IDLE;
      end
      default: begin
        if (a) begin
          push_evt(EV_CHG, m_chg[0], m_bal);
          m_bal -= coin_cents[m_chg[0]];
          void'(m_chg.pop_front());
          if (m_bal == 0) m_state = M_IDLE;
        end
        if (cv) push_evt(EV_REJ, 0, m_bal);
      end
    endcase
  endtask

  task automatic cyc(bit r, bit cv, bit [1:0] c, bit iv, bit [1:0] it, bit can, bit ack);
    @(posedge clk);
    #1;
    step(r, cv, c, iv, it, can, ack);
  endtask

  task automatic idle(int n, bit ack);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, ack);
  endtask

  task automatic coin(bit [1:0] c);
    cyc(1'b1, 1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic item(bit [1:0] it);
    cyc(1'b1, 1'b0, 2'd0, 1'b1, it, 1'b0, 1'b0);
  endtask

  task automatic chk_evt(int kind, int data);
    evt_t e;
    checks++;
    if (evt_q.size() == 0) begin
      failures++;
      $display("FAIL event_unexpected t=%0t kind=%0d data=%0d (queue empty)", $time, kind, data);
    end else begin
      e = evt_q.pop_front();
      if (e.kind != kind || e.data != data || e.bal != int'(bus.balance)) begin
        failures++;
        $display("FAIL event t=%0t actual kind=%0d data=%0d bal=%0d required kind=%0d data=%0d bal=%0d",
                 $time, kind, data, bus.balance, e.kind, e.data, e.bal);
      end
    end
  endtask

  always @(negedge clk) begin
    stat_t s;
    if (mon_en) begin
      checks++;
      if (stat_q.size() == 0) begin
        failures++;
        $display("FAIL status_underflow t=%0t", $time);
      end else begin
        s = stat_q.pop_front();
        if (int'(bus.state_out) != s.st || int'(bus.balance) != s.bal ||
            int'(bus.change_valid) != s.cv ||
            (s.cv == 1 && int'(bus.change_coin) != s.cc)) begin
          failures++;
          $display("FAIL status t=%0t actual st=%0h bal=%0d cv=%0d cc=%0d required st=%0h bal=%0d cv=%0d cc=%0d",
                   $time, bus.state_out, bus.balance, bus.change_valid, bus.change_coin,
                   s.st, s.bal, s.cv, s.cc);
        end
      end
      if (bus.dispense)                       chk_evt(EV_DISP, int'(bus.dispense_item));
      if (bus.coin_reject)                    chk_evt(EV_REJ, 0);
      if (bus.insufficient)                   chk_evt(EV_INS, 0);
      if (bus.change_valid && bus.change_ack) chk_evt(EV_CHG, int'(bus.change_coin));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pc, pi, pk;
    bit r;
    bus.coin_valid = 1'b0; bus.coin = 2'd0; bus.item_valid = 1'b0; bus.item = 2'd0;
    bus.cancel = 1'b0; bus.change_ack = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);

    // Coin 50 + 5, buy item 1, one 5-cent coin back.
    coin(2'd3); coin(2'd0); item(2'd1); idle(4, 1'b1);
    // Too little credit, then refund.
    coin(2'd1); item(2'd0); idle(2, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0); idle(3, 1'b1);
    // 125 cents refunded back-to-back.
    coin(2'd3); coin(2'd3); coin(2'd2);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1); idle(5, 1'b1);
    // Saturation at 250.
    repeat (6) coin(2'd3);
    idle(1, 1'b0);
    cyc(1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0); idle(8, 1'b1);
    // Timeout refund with a stalled payout.
    coin(2'd2); idle(TO + 1 + 6, 1'b0); idle(3, 1'b1);
    // Cancel beats coin, then reset mid-payout.
    coin(2'd2);
    cyc(1'b1, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(2, 1'b0);

    for (int blk = 0; blk < 30; blk++) begin
      pc = ($urandom_range(0, 1) == 1) ? 30 : 3;
      pi = ($urandom_range(0, 1) == 1) ? 15 : 2;
      pk = ($urandom_range(0, 3) == 0) ? 4 : 0;
      for (int n = 0; n < 100; n++) begin
        r = ($urandom_range(0, 599) != 0);
        cyc(r, ($urandom_range(0, 99) < pc), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < pi), 2'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < pk), ($urandom_range(0, 1) == 1));
      end
    end

    idle(TO + 20, 1'b1);
    @(negedge clk);
    #1;
    checks++;
    if (evt_q.size() != 0 || stat_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual events_left=%0d status_left=%0d required 0/0",
               evt_q.size(), stat_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
